// File: rtl/adc_cfg_sequencer.sv
// adc_cfg_sequencer: resets the delta-sigma ADC through the SPI command
// master, waits out its power-up time, then writes each configuration word
// and verifies the echoed response. Restarts on reset release and on sync_req.
module adc_cfg_sequencer #(
    parameter int                WORD_W            = 24,
    parameter int                N_CFG             = 4,
    parameter logic [WORD_W-1:0] RESET_CMD         = 24'h000011,
    parameter int                RESET_WAIT_TICKS  = 4096,
    parameter int                RSP_TIMEOUT_TICKS = 1024,
    parameter int                MAX_RETRIES       = 3
) (
    input  logic                    clk_ctrl,
    input  logic                    rst_ctrl_n,
    input  logic                    sync_req,
    input  logic [N_CFG*WORD_W-1:0] cfg_words,
    output logic                    spi_tx_valid,
    input  logic                    spi_tx_ready,
    output logic [WORD_W-1:0]       spi_tx_data,
    input  logic                    spi_rx_valid,
    input  logic [WORD_W-1:0]       spi_rx_data,
    output logic                    busy,
    output logic                    cfg_ok,
    output logic                    cfg_err,
    output logic [2:0]              retry_cnt,
    output logic [2:0]              state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND_RST = 3'd1,
        WAIT_RST = 3'd2,
        SEND_CFG = 3'd3,
        WAIT_RSP = 3'd4,
        READY    = 3'd5,
        ERROR    = 3'd6
    } state_t;

    localparam logic [3:0]  LAST_IDX  = 4'(N_CFG - 1);
    localparam logic [15:0] RST_LAST  = 16'(RESET_WAIT_TICKS - 1);
    localparam logic [15:0] RSP_LAST  = 16'(RSP_TIMEOUT_TICKS - 1);
    localparam logic [2:0]  RETRY_MAX = 3'(MAX_RETRIES);

    state_t            cur;
    logic [3:0]        idx;
    logic [15:0]       cnt;
    logic              sync_pend;
    logic              restart;
    logic [WORD_W-1:0] cur_word;
    logic [WORD_W-1:0] next_word;

    assign state     = cur;
    assign cur_word  = cfg_words[idx*WORD_W +: WORD_W];
    assign next_word = cfg_words[(idx + 4'd1)*WORD_W +: WORD_W];

    // A restart is taken at boot, on sync in a resting state, or once a
    // pending sync can be honoured without dropping an unaccepted command.
    assign restart = (cur == IDLE)
                   || (((cur == READY) || (cur == ERROR)) && sync_req)
                   || (((cur == WAIT_RST) || (cur == WAIT_RSP)) && (sync_req || sync_pend));

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk_ctrl or negedge rst_ctrl_n) begin
        if (!rst_ctrl_n) begin
            cur          <= IDLE;
            idx          <= 4'd0;
            cnt          <= 16'd0;
            sync_pend    <= 1'b0;
            spi_tx_valid <= 1'b0;
            spi_tx_data  <= '0;
            busy         <= 1'b0;
            cfg_ok       <= 1'b0;
            cfg_err      <= 1'b0;
            retry_cnt    <= 3'd0;
        end else if (restart) begin
            cur          <= SEND_RST;
            idx          <= 4'd0;
            cnt          <= 16'd0;
            sync_pend    <= 1'b0;
            spi_tx_valid <= 1'b1;
            spi_tx_data  <= RESET_CMD;
            busy         <= 1'b1;
            cfg_ok       <= 1'b0;
            cfg_err      <= 1'b0;
            retry_cnt    <= 3'd0;
        end else begin
            case (cur)
                SEND_RST, SEND_CFG: begin
                    if (sync_req) begin
                        sync_pend <= 1'b1;
                    end
                    if (spi_tx_ready) begin
                        cur          <= (cur == SEND_RST) ? WAIT_RST : WAIT_RSP;
                        cnt          <= 16'd0;
                        spi_tx_valid <= 1'b0;
                    end
                end
                WAIT_RST: begin
                    if (cnt == RST_LAST) begin
                        cur          <= SEND_CFG;
                        idx          <= 4'd0;
                        spi_tx_valid <= 1'b1;
                        spi_tx_data  <= cfg_words[WORD_W-1:0];
                    end else if (cnt != 16'hFFFF) begin
                        cnt <= cnt + 16'd1;
                    end
                end
                WAIT_RSP: begin
                    if (spi_rx_valid && (spi_rx_data == cur_word)) begin
                        if (idx == LAST_IDX) begin
                            cur    <= READY;
                            busy   <= 1'b0;
                            cfg_ok <= 1'b1;
                        end else begin
                            cur          <= SEND_CFG;
                            idx          <= idx + 4'd1;
                            spi_tx_valid <= 1'b1;
                            spi_tx_data  <= next_word;
                        end
                    end else if (spi_rx_valid || (cnt == RSP_LAST)) begin
                        if (retry_cnt < RETRY_MAX) begin
                            cur          <= SEND_RST;
                            idx          <= 4'd0;
                            retry_cnt    <= retry_cnt + 3'd1;
                            spi_tx_valid <= 1'b1;
                            spi_tx_data  <= RESET_CMD;
                        end else begin
                            cur     <= ERROR;
                            busy    <= 1'b0;
                            cfg_err <= 1'b1;
                        end
                    end else if (cnt != 16'hFFFF) begin
                        cnt <= cnt + 16'd1;
                    end
                end
                READY, ERROR: begin
                end
                default: begin
                    cur          <= IDLE;
                    spi_tx_valid <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_cfg_sequencer.sv
// Testbench for adc_cfg_sequencer: directed scenarios with an echoing SPI
// responder, a time-stamp based reference model checked every cycle, and
// hand-computed latency and handshake expectations.
module tb_adc_cfg_sequencer;

    localparam int          WORD_W      = 24;
    localparam int          N_CFG       = 4;
    localparam logic [23:0] RESET_CMD   = 24'h000011;
    localparam int          RST_TICKS   = 8;
    localparam int          RSP_TICKS   = 12;
    localparam int          MAX_RETRIES = 3;

    logic                    clk_ctrl     = 1'b0;
    logic                    rst_ctrl_n   = 1'b0;
    logic                    sync_req     = 1'b0;
    logic [N_CFG*WORD_W-1:0] cfg_words;
    logic                    spi_tx_valid;
    logic                    spi_tx_ready = 1'b0;
    logic [WORD_W-1:0]       spi_tx_data;
    logic                    spi_rx_valid = 1'b0;
    logic [WORD_W-1:0]       spi_rx_data  = '0;
    logic                    busy;
    logic                    cfg_ok;
    logic                    cfg_err;
    logic [2:0]              retry_cnt;
    logic [2:0]              state;

    logic [23:0] words [N_CFG] = '{24'hA50102, 24'h3C1234, 24'h5A0F0F, 24'hC37E81};

    for (genvar g = 0; g < N_CFG; g++) begin : g_words
        assign cfg_words[g*WORD_W +: WORD_W] = words[g];
    end

    adc_cfg_sequencer #(
        .WORD_W(WORD_W), .N_CFG(N_CFG), .RESET_CMD(RESET_CMD),
        .RESET_WAIT_TICKS(RST_TICKS), .RSP_TIMEOUT_TICKS(RSP_TICKS),
        .MAX_RETRIES(MAX_RETRIES)
    ) dut (
        .clk_ctrl(clk_ctrl), .rst_ctrl_n(rst_ctrl_n), .sync_req(sync_req),
        .cfg_words(cfg_words), .spi_tx_valid(spi_tx_valid),
        .spi_tx_ready(spi_tx_ready), .spi_tx_data(spi_tx_data),
        .spi_rx_valid(spi_rx_valid), .spi_rx_data(spi_rx_data),
        .busy(busy), .cfg_ok(cfg_ok), .cfg_err(cfg_err),
        .retry_cnt(retry_cnt), .state(state)
    );

    always #5 clk_ctrl = ~clk_ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    // Bench-side stimulus state: responder, handshake log, control knobs.
    int          edges        = 0;
    bit          resp_pending = 0;
    int          resp_due     = 0;
    logic [23:0] resp_word    = '0;
    bit          echo_en      = 1;
    int          corrupt_word = -1;
    bit          ready_level  = 1;
    bit          sync_next    = 0;
    logic [23:0] hs_log [$];

    // Reference model: phase codes from the state list, waits measured as
    // elapsed cycles since the handshake that started them.
    int m_phase   = 0;
    int m_retries = 0;
    int m_word    = 0;
    int m_t0      = 0;
    int cyc       = 0;
    bit m_pend    = 0;

    // Advance the reference model on every clock edge or reset assertion.
    always @(posedge clk_ctrl or negedge rst_ctrl_n) begin
        if (!rst_ctrl_n) begin
            m_phase   <= 0;
            m_retries <= 0;
            m_word    <= 0;
            m_pend    <= 0;
            m_t0      <= 0;
            cyc       <= 0;
        end else begin
            cyc <= cyc + 1;
            if (m_phase == 0 || ((m_phase == 5 || m_phase == 6) && sync_req)
                || ((m_phase == 2 || m_phase == 4) && (sync_req || m_pend))) begin
                m_phase   <= 1;
                m_retries <= 0;
                m_word    <= 0;
                m_pend    <= 0;
            end else if (m_phase == 1 || m_phase == 3) begin
                if (sync_req) m_pend <= 1;
                if (spi_tx_ready) begin
                    m_phase <= m_phase + 1;
                    m_t0    <= cyc;
                end
            end else if (m_phase == 2) begin
                if (cyc - m_t0 == RST_TICKS) begin
                    m_phase <= 3;
                    m_word  <= 0;
                end
            end else if (m_phase == 4) begin
                if (spi_rx_valid && spi_rx_data == words[m_word]) begin
                    if (m_word == N_CFG - 1) m_phase <= 5;
                    else begin
                        m_word  <= m_word + 1;
                        m_phase <= 3;
                    end
                end else if (spi_rx_valid || (cyc - m_t0 == RSP_TICKS)) begin
                    if (m_retries < MAX_RETRIES) begin
                        m_retries <= m_retries + 1;
                        m_word    <= 0;
                        m_phase   <= 1;
                    end else begin
                        m_phase <= 6;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic compareModel();
        checkOutput("state", 32'(state), 32'(m_phase));
        checkOutput("busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= 4));
        checkOutput("cfg_ok", 32'(cfg_ok), 32'(m_phase == 5));
        checkOutput("cfg_err", 32'(cfg_err), 32'(m_phase == 6));
        checkOutput("retry_cnt", 32'(retry_cnt), 32'(m_retries));
        checkOutput("tx_valid", 32'(spi_tx_valid), 32'(m_phase == 1 || m_phase == 3));
        if (m_phase == 1) checkOutput("tx_data_rst", 32'(spi_tx_data), 32'(RESET_CMD));
        else if (m_phase == 3) checkOutput("tx_data_cfg", 32'(spi_tx_data), 32'(words[m_word]));
    endtask

    // One clock cycle: compare at the falling edge, then drive the inputs
    // for the next rising edge and act as the echoing SPI slave.
    task automatic applyStimulus();
        @(negedge clk_ctrl);
        edges++;
        compareModel();
        spi_tx_ready = ready_level;
        sync_req     = sync_next;
        sync_next    = 0;
        if (resp_pending && edges == resp_due) begin
            spi_rx_valid = 1'b1;
            spi_rx_data  = resp_word;
            resp_pending = 0;
        end else begin
            spi_rx_valid = 1'b0;
        end
        if (spi_tx_valid && spi_tx_ready) begin
            hs_log.push_back(spi_tx_data);
            if (echo_en && spi_tx_data != RESET_CMD) begin
                resp_pending = 1;
                resp_due     = edges + 5;
                resp_word    = spi_tx_data;
                if (corrupt_word >= 0 && spi_tx_data == words[corrupt_word]) begin
                    resp_word    = resp_word ^ 24'h000100;
                    corrupt_word = -1;
                end
            end
        end
    endtask

    task automatic waitFor(input int target, input int budget, input string name, output int took);
        took = 0;
        while (state != 3'(target) && took < budget) begin
            applyStimulus();
            took++;
        end
        checkOutput(name, 32'(state), 32'(target));
    endtask

    int took;
    int base;
    int guard;

    initial begin
        repeat (3) applyStimulus();
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_valid", 32'(spi_tx_valid), 32'd0);
        checkOutput("rst_data", 32'(spi_tx_data), 32'd0);
        checkOutput("rst_flags", {29'd0, busy, cfg_ok, cfg_err}, 32'd0);

        // Clean boot
        rst_ctrl_n = 1'b1;
        #1 checkOutput("boot_idle", 32'(state), 32'd0);
        base = hs_log.size();
        applyStimulus();
        checkOutput("boot_send_rst", 32'(state), 32'd1);
        checkOutput("boot_valid", 32'(spi_tx_valid), 32'd1);
        checkOutput("boot_data", 32'(spi_tx_data), 32'(RESET_CMD));
        waitFor(5, 300, "boot_ready", took);
        checkOutput("boot_latency", 32'(took), 32'd33);
        checkOutput("boot_retry", 32'(retry_cnt), 32'd0);
        checkOutput("boot_hs_count", 32'(hs_log.size() - base), 32'd5);
        if (hs_log.size() > base) checkOutput("boot_hs_first", 32'(hs_log[base]), 32'(RESET_CMD));

        // Resync from READY with a corrupted echo of word 2
        corrupt_word = 2;
        base = hs_log.size();
        sync_next = 1;
        applyStimulus();
        applyStimulus();
        checkOutput("resync_ok_drop", 32'(cfg_ok), 32'd0);
        checkOutput("resync_state", 32'(state), 32'd1);
        waitFor(5, 300, "mismatch_ready", took);
        checkOutput("mismatch_retry", 32'(retry_cnt), 32'd1);
        checkOutput("mismatch_hs_count", 32'(hs_log.size() - base), 32'd9);
        if (hs_log.size() >= base + 9) begin
            checkOutput("mismatch_hs3", 32'(hs_log[base+3]), 32'(words[2]));
            checkOutput("mismatch_hs4", 32'(hs_log[base+4]), 32'(RESET_CMD));
        end

        // Timeout on every attempt leads to ERROR
        echo_en = 0;
        base = hs_log.size();
        sync_next = 1;
        applyStimulus();
        waitFor(6, 400, "timeout_error", took);
        checkOutput("timeout_latency", 32'(took), 32'd89);
        checkOutput("timeout_err", 32'(cfg_err), 32'd1);
        checkOutput("timeout_retry", 32'(retry_cnt), 32'd3);
        checkOutput("timeout_busy", 32'(busy), 32'd0);
        checkOutput("timeout_hs_count", 32'(hs_log.size() - base), 32'd8);

        // Resync from ERROR
        echo_en = 1;
        sync_next = 1;
        applyStimulus();
        applyStimulus();
        checkOutput("err_resync_err", 32'(cfg_err), 32'd0);
        checkOutput("err_resync_state", 32'(state), 32'd1);
        waitFor(5, 300, "err_resync_ready", took);
        checkOutput("err_resync_retry", 32'(retry_cnt), 32'd0);

        // Backpressure in SEND_CFG with a sync pulse
        sync_next = 1;
        applyStimulus();
        waitFor(2, 50, "bp_wait_rst", took);
        ready_level = 0;
        waitFor(3, 50, "bp_send_cfg", took);
        for (int i = 0; i < 6; i++) begin
            if (i == 1) sync_next = 1;
            applyStimulus();
            checkOutput("bp_valid_hold", 32'(spi_tx_valid), 32'd1);
            checkOutput("bp_data_hold", 32'(spi_tx_data), 32'(words[0]));
        end
        ready_level = 1;
        base = hs_log.size();
        guard = 0;
        while (hs_log.size() < base + 2 && guard < 40) begin
            applyStimulus();
            guard++;
        end
        checkOutput("bp_hs_count", 32'(hs_log.size() - base), 32'd2);
        if (hs_log.size() >= base + 2) begin
            checkOutput("bp_hs_word", 32'(hs_log[base]), 32'(words[0]));
            checkOutput("bp_hs_next", 32'(hs_log[base+1]), 32'(RESET_CMD));
        end
        waitFor(5, 300, "bp_ready", took);

        // Asynchronous reset in the middle of WAIT_RST
        sync_next = 1;
        applyStimulus();
        waitFor(2, 50, "ar_wait_rst", took);
        repeat (3) applyStimulus();
        #2 rst_ctrl_n = 1'b0;
        resp_pending = 0;
        #1;
        checkOutput("ar_state", 32'(state), 32'd0);
        checkOutput("ar_valid", 32'(spi_tx_valid), 32'd0);
        checkOutput("ar_data", 32'(spi_tx_data), 32'd0);
        checkOutput("ar_flags", {29'd0, busy, cfg_ok, cfg_err}, 32'd0);
        checkOutput("ar_retry", 32'(retry_cnt), 32'd0);
        repeat (2) applyStimulus();
        rst_ctrl_n = 1'b1;
        #1 checkOutput("ar_boot_idle", 32'(state), 32'd0);
        applyStimulus();
        checkOutput("ar_boot_send_rst", 32'(state), 32'd1);
        waitFor(5, 300, "ar_boot_ready", took);
        checkOutput("ar_boot_latency", 32'(took), 32'd33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
